// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller for the 5-stage pipeline: drives the global pipeline
// enable and clear, drains in-flight instructions after HALT and counts enabled cycles.
module pipeline_sequencer #(
    parameter logic [5:0] HALT_OPCODE  = 6'b111_111,
    parameter int         DRAIN_CYCLES = 3,
    parameter int         CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             step,
    input  logic [5:0]       id_opcode,
    output logic             pipe_enable,
    output logic             pipe_reset,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        STEP_EXEC = 3'd4,
        DRAIN     = 3'd5,
        HALTED    = 3'd6
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t           state_reg;
    logic             run_mode_reg;
    logic [3:0]       drain_cnt_reg;
    logic [CNT_W-1:0] cycle_count_reg;

    logic halt_in_id;
    assign halt_in_id = (id_opcode == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            run_mode_reg    <= 1'b0;
            drain_cnt_reg   <= 4'd0;
            cycle_count_reg <= '0;
        end else begin
            // Saturating count of enabled cycles; the start edge below overrides it.
            if (pipe_enable && (cycle_count_reg != {CNT_W{1'b1}}))
                cycle_count_reg <= cycle_count_reg + 1'b1;

            case (state_reg)
                IDLE, HALTED: begin
                    if (start) begin
                        run_mode_reg    <= mode;
                        cycle_count_reg <= '0;
                        state_reg       <= CLEAR;
                    end
                end
                CLEAR: state_reg <= run_mode_reg ? STEP_WAIT : RUN;
                RUN: begin
                    if (halt_in_id) begin
                        drain_cnt_reg <= DRAIN_LOAD;
                        state_reg     <= DRAIN;
                    end
                end
                STEP_WAIT: begin
                    if (step)
                        state_reg <= STEP_EXEC;
                end
                STEP_EXEC: begin
                    if (halt_in_id) begin
                        drain_cnt_reg <= DRAIN_LOAD;
                        state_reg     <= DRAIN;
                    end else begin
                        state_reg <= STEP_WAIT;
                    end
                end
                DRAIN: begin
                    // Free-running in both modes; further HALTs in ID are ignored.
                    drain_cnt_reg <= drain_cnt_reg - 4'd1;
                    if (drain_cnt_reg == 4'd1)
                        state_reg <= HALTED;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        pipe_enable = 1'b0;
        pipe_reset  = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            CLEAR:     begin pipe_reset  = 1'b1; busy = 1'b1; end
            RUN:       begin pipe_enable = 1'b1; busy = 1'b1; end
            STEP_WAIT: begin busy = 1'b1; end
            STEP_EXEC: begin pipe_enable = 1'b1; busy = 1'b1; end
            DRAIN:     begin pipe_enable = 1'b1; busy = 1'b1; end
            HALTED:    begin halted = 1'b1; end
            default:   begin end
        endcase
    end

    assign cycle_count = cycle_count_reg;
    assign state_dbg   = state_reg;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed-vector bench: stimulus pushes expected per-cycle outputs into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_pipeline_sequencer;

    localparam logic [5:0] HALT = 6'b111_111;
    localparam logic [5:0] NOP  = 6'b000_000;
    localparam int S_IDLE = 0, S_CLEAR = 1, S_RUN = 2, S_WAIT = 3,
                   S_EXEC = 4, S_DRAIN = 5, S_HALTED = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        step = 1'b0;
    logic [5:0]  id_opcode = NOP;
    logic        pipe_enable, pipe_reset, busy, halted;
    logic [31:0] cycle_count;
    logic [2:0]  state_dbg;

    pipeline_sequencer #(
        .HALT_OPCODE (HALT),
        .DRAIN_CYCLES(3),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .step       (step),
        .id_opcode  (id_opcode),
        .pipe_enable(pipe_enable),
        .pipe_reset (pipe_reset),
        .busy       (busy),
        .halted     (halted),
        .cycle_count(cycle_count),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    st;
        int    cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_no = 0;

    // Expected flag vector {pipe_enable, pipe_reset, busy, halted} for a state.
    function automatic logic [3:0] flags_for(input int st);
        case (st)
            S_CLEAR:  return 4'b0110;
            S_RUN:    return 4'b1010;
            S_WAIT:   return 4'b0010;
            S_EXEC:   return 4'b1010;
            S_DRAIN:  return 4'b1010;
            S_HALTED: return 4'b0001;
            default:  return 4'b0000;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [3:0] got_f, exp_f;
            e     = exp_q.pop_front();
            exp_f = flags_for(e.st);
            got_f = {pipe_enable, pipe_reset, busy, halted};
            total++;
            if (state_dbg !== 3'(e.st) || got_f !== exp_f || cycle_count !== 32'(e.cnt)) begin
                bad++;
                $display("FAIL %s: got state=%0d en/rst/busy/halt=%b count=%0d, want state=%0d en/rst/busy/halt=%b count=%0d",
                         e.name, state_dbg, got_f, cycle_count, e.st, exp_f, e.cnt);
            end else begin
                $display("ok   %s: state=%0d en/rst/busy/halt=%b count=%0d",
                         e.name, state_dbg, got_f, cycle_count);
            end
        end
    end

    // Apply inputs for one cycle, then queue the expected outputs after that edge.
    task automatic tick(input string name, input logic rst, input logic st_in,
                        input logic md, input logic stp, input logic [5:0] op,
                        input int exp_st, input int exp_cnt);
        exp_t e;
        reset = rst; start = st_in; mode = md; step = stp; id_opcode = op;
        @(posedge clk);
        #1;
        cyc_no++;
        e.name = $sformatf("%s@%0d", name, cyc_no);
        e.st   = exp_st;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        reset = 1'b0; start = 1'b0; step = 1'b0; id_opcode = NOP;
    endtask

    initial begin
        @(negedge clk);
        // Reset held, then idle with no stimulus.
        for (int i = 0; i < 3; i++) tick("reset", 1, 0, 0, 0, NOP, S_IDLE, 0);
        for (int i = 0; i < 10; i++) tick("idle", 0, 0, 0, 0, NOP, S_IDLE, 0);

        // Continuous run, HALT on 5th RUN cycle, start ignored in RUN.
        tick("start_run", 0, 1, 0, 0, NOP, S_CLEAR, 0);
        tick("run1", 0, 0, 1, 0, NOP, S_RUN, 0);
        tick("run2", 0, 0, 0, 0, NOP, S_RUN, 1);
        tick("run3_start_ignored", 0, 1, 1, 0, NOP, S_RUN, 2);
        tick("run4", 0, 0, 0, 0, NOP, S_RUN, 3);
        tick("run5", 0, 0, 0, 0, NOP, S_RUN, 4);
        tick("halt_in_id", 0, 0, 0, 0, HALT, S_DRAIN, 5);
        tick("drain2_halt_again", 0, 0, 0, 0, HALT, S_DRAIN, 6);
        tick("drain3", 0, 0, 0, 0, HALT, S_DRAIN, 7);
        tick("halted", 0, 0, 0, 0, NOP, S_HALTED, 8);
        for (int i = 0; i < 20; i++)
            tick("halted_hold", 0, 0, 0, (i % 4) == 0, HALT, S_HALTED, 8);

        // Restart from HALTED in step mode; 4 steps spaced 5 cycles apart.
        tick("restart_step", 0, 1, 1, 0, NOP, S_CLEAR, 0);
        tick("step_wait", 0, 0, 0, 0, NOP, S_WAIT, 0);
        for (int k = 0; k < 4; k++) begin
            tick("step_exec", 0, 0, 0, 1, NOP, S_EXEC, k);
            // Second step during STEP_EXEC on the first pulse must be dropped.
            tick("step_back", 0, 0, 0, k == 0, NOP, S_WAIT, k + 1);
            for (int j = 0; j < 3; j++)
                tick("step_idle", 0, 0, 0, 0, NOP, S_WAIT, k + 1);
        end

        // Reset, then step run with HALT on the 3rd step; start+step together.
        tick("reset2", 1, 0, 0, 0, NOP, S_IDLE, 0);
        tick("start_with_step", 0, 1, 1, 1, NOP, S_CLEAR, 0);
        tick("wait0", 0, 0, 0, 0, NOP, S_WAIT, 0);
        tick("s1", 0, 0, 0, 1, NOP, S_EXEC, 0);
        tick("s1_done", 0, 0, 0, 0, NOP, S_WAIT, 1);
        tick("s2", 0, 0, 0, 1, NOP, S_EXEC, 1);
        tick("s2_done", 0, 0, 0, 0, NOP, S_WAIT, 2);
        tick("wait_halt_ignored", 0, 0, 0, 0, HALT, S_WAIT, 2);
        tick("s3", 0, 0, 0, 1, NOP, S_EXEC, 2);
        tick("s3_halt", 0, 0, 0, 0, HALT, S_DRAIN, 3);
        tick("sdrain2", 0, 0, 0, 1, NOP, S_DRAIN, 4);
        tick("sdrain3", 0, 0, 0, 0, NOP, S_DRAIN, 5);
        tick("shalted", 0, 0, 0, 0, NOP, S_HALTED, 6);
        for (int i = 0; i < 4; i++) tick("shalted_step", 0, 0, 0, 1, NOP, S_HALTED, 6);

        // Restart continuous, then reset mid-DRAIN.
        tick("restart_run", 0, 1, 0, 0, NOP, S_CLEAR, 0);
        tick("r_run", 0, 0, 0, 0, NOP, S_RUN, 0);
        tick("r_halt", 0, 0, 0, 0, HALT, S_DRAIN, 1);
        tick("r_drain2", 0, 0, 0, 0, NOP, S_DRAIN, 2);
        tick("reset_mid_drain", 1, 0, 0, 0, NOP, S_IDLE, 0);
        for (int i = 0; i < 3; i++) tick("post_reset", 0, 0, 0, 0, NOP, S_IDLE, 0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Run/step/halt controller for the 5-stage MIPS pipeline; sits beside the ID-stage decoder.
- Issues a single global pipeline enable that gates every pipeline register and the PC.
- On start, clears the pipeline with a one-cycle pipeline reset pulse.
- Runs continuously or one cycle per step request.
- On a HALT opcode in ID, drains the instructions already in flight, then reports halted with an enabled-cycle count for the debug unit.

Parameters:
- HALT_OPCODE, 6'b111_111, ID-stage opcode that terminates execution.
- DRAIN_CYCLES, 3, enabled cycles after HALT leaves ID (EX, MEM, WB); legal range 1..15.
- CNT_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- start  in  1  one-cycle pulse; begins a program run
- mode  in  1  sampled with start: 0 = continuous, 1 = step
- step  in  1  one-cycle pulse; advances one cycle in step mode
- id_opcode  in  6  opcode[31:26] of the instruction currently in ID
- pipe_enable  out  1  gates all pipeline registers and the PC
- pipe_reset  out  1  one-cycle clear of pipeline registers and PC
- busy  out  1  high in any state other than IDLE/HALTED
- halted  out  1  high in HALTED
- cycle_count  out  CNT_W  number of cycles with pipe_enable=1 since the last start
- state_dbg  out  3  current state encoding

Behaviour:
- Reset state and outputs:
  - State = IDLE.
  - pipe_enable=0, pipe_reset=0, busy=0, halted=0, cycle_count=0.
  - Reset asserted in any state returns to IDLE on that edge; no drain completes.
- State encoding: IDLE=0, CLEAR=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, DRAIN=5, HALTED=6.
- All outputs are Moore decodes of the registered state/counters, with no combinational path from inputs.
- IDLE:
  - start=1 latches mode into run_mode, zeroes cycle_count, and moves to CLEAR.
- CLEAR (exactly 1 cycle):
  - pipe_reset=1, pipe_enable=0.
  - Next state: RUN if run_mode=0, otherwise STEP_WAIT.
- RUN:
  - pipe_enable=1.
  - If id_opcode==HALT_OPCODE, load drain_cnt=DRAIN_CYCLES and go to DRAIN. Otherwise stay.
- STEP_WAIT:
  - pipe_enable=0.
  - step=1 moves to STEP_EXEC.
- STEP_EXEC (exactly 1 cycle):
  - pipe_enable=1.
  - If id_opcode==HALT_OPCODE, load drain_cnt and go to DRAIN; otherwise go to STEP_WAIT.
  - A step asserted during STEP_EXEC is dropped, not queued.
- DRAIN:
  - pipe_enable=1; drain_cnt decrements each cycle.
  - When drain_cnt==1, go to HALTED, so DRAIN lasts exactly DRAIN_CYCLES cycles in both modes.
  - id_opcode is ignored in DRAIN; a second HALT in flight does not extend the drain.
- HALTED:
  - pipe_enable=0, halted=1; cycle_count holds its value.
  - start=1 behaves as in IDLE: clears halted, zeroes the count, goes to CLEAR.
- cycle_count:
  - +1 on every edge where pipe_enable=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Zeroed on the start-acceptance edge.
- Ignored inputs:
  - start ignored while busy=1.
  - step ignored outside STEP_WAIT.
  - mode ignored except on the start-acceptance edge.
- Simultaneous events: start and step on the same cycle in IDLE means start is taken and step is dropped.
- busy = state in {CLEAR, RUN, STEP_WAIT, STEP_EXEC, DRAIN}.
- drain_cnt width is 4 bits; DRAIN_CYCLES=0 is illegal and is not supported.
- Latency:
  - start to first pipe_enable = 2 edges (IDLE, then CLEAR, then RUN).
  - HALT seen in ID to halted=1 = DRAIN_CYCLES+1 edges.

Test Plan:
- Reset held 3 cycles, then released with no stimulus -> pipe_enable=0, busy=0, halted=0, cycle_count=0, state_dbg=0 for 10 cycles.
- start with mode=0, id_opcode=HALT on the 5th RUN cycle, DRAIN_CYCLES=3 -> pipe_reset high for exactly 1 cycle; pipe_enable high for 8 consecutive cycles; then halted=1, busy=0, cycle_count=8, held for 20 cycles.
- start with mode=1 and 4 step pulses spaced 5 cycles apart, no HALT -> pipe_enable high for exactly 1 cycle after each step; cycle_count=4; state returns to 3 between steps.
- Step mode with HALT present on the 3rd step -> after that STEP_EXEC, 3 free-running DRAIN cycles with no further steps needed; halted=1, cycle_count=6; extra step pulses cause no change.
- Overlap and restart:
  - start pulsed in RUN -> no effect.
  - start in HALTED -> cycle_count returns to 0, pipe_reset pulses, run restarts.
  - step pulsed during STEP_EXEC -> only one enable cycle occurs.
- Reset asserted mid-DRAIN (drain_cnt=2) -> next edge state_dbg=0, pipe_enable=0, halted stays 0, cycle_count=0.
